// File: rtl/output_bus_pkg.sv
// output_bus_pkg: shared FSM state type and bus/word widths for the output bus arbiter
package output_bus_pkg;
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/output_bus_arbiter_if.sv
// output_bus_arbiter_if: requester side (req, data, gnt, done) and byte bus side (bus, bus_valid, bus_ready, bus_id, byte_idx, busy)
interface output_bus_arbiter_if #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) ();
  import output_bus_pkg::*;
  logic [N-1:0]        req;
  logic [WORD_W*N-1:0] data;
  logic                bus_ready;
  logic [BYTE_W-1:0]   bus;
  logic                bus_valid;
  logic [IDW-1:0]      bus_id;
  logic                byte_idx;
  logic [N-1:0]        gnt;
  logic [N-1:0]        done;
  logic                busy;
  modport master (input req, data, bus_ready, output bus, bus_valid, bus_id, byte_idx, gnt, done, busy);
  modport slave (output req, data, bus_ready, input bus, bus_valid, bus_id, byte_idx, gnt, done, busy);
endinterface

// File: rtl/output_bus_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req_i/ptr_i in, first set req at or above ptr_i (mod N) as winner_o, any_o = |req_i
module rr_arbiter #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] winner_o,
  output logic           any_o
);
  always_comb begin
    winner_o = '0;
    for (int i = N - 1; i >= 0; i--)
      winner_o = req_i[(int'(ptr_i) + i) % N] ? IDW'((int'(ptr_i) + i) % N) : winner_o;
  end
  assign any_o = |req_i;
endmodule

// File: rtl/output_bus_arbiter.sv
// output_bus_arbiter: grants one of N requesters round-robin and sends its captured 16-bit word as two bytes (hi first); clk, rst (async active-low), ob (master modport)
module output_bus_arbiter
  import output_bus_pkg::*;
#(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input logic               clk,
  input logic               rst,
  output_bus_arbiter_if.master ob
);
  state_t              state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d, id_q, id_d, winner;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [N-1:0]        gnt_q, gnt_d, done_q, done_d;
  logic                any_req;
  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req_i   (ob.req),
    .ptr_i   (rr_q),
    .winner_o(winner),
    .any_o   (any_req)
  );
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = SEND_HI;
        id_d    = winner;
        gnt_d   = N'(1) << winner;
        hold_d  = ob.data[WORD_W*winner +: WORD_W];
      end
      SEND_HI: if (ob.bus_ready) state_d = SEND_LO;
      SEND_LO: if (ob.bus_ready) begin
        state_d = IDLE;
        gnt_d   = '0;
        done_d  = N'(1) << id_q;
        rr_d    = id_q == IDW'(N - 1) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end
  assign ob.bus       = state_q == SEND_HI ? hold_q[WORD_W-1:BYTE_W] : state_q == SEND_LO ? hold_q[BYTE_W-1:0] : '0;
  assign ob.bus_valid = state_q != IDLE;
  assign ob.busy      = state_q != IDLE;
  assign ob.byte_idx  = state_q == SEND_LO;
  assign ob.bus_id    = id_q;
  assign ob.gnt       = gnt_q;
  assign ob.done      = done_q;
endmodule

// File: tb/tb_output_bus_arbiter.sv
// tb_output_bus_arbiter: directed and random stimulus checked against a transaction-level byte-queue model
module tb_output_bus_arbiter;
  localparam int N = 4;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  output_bus_arbiter_if #(.N(N)) ob ();
  output_bus_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .ob(ob));
  int checks = 0;
  int errors = 0;
  int owner = -1;
  int ptr = 0;
  int exp_done = -1;
  logic [7:0] q[$];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    logic v;
    v = owner >= 0;
    check("bus_valid", 32'(ob.bus_valid), 32'(v));
    check("busy", 32'(ob.busy), 32'(v));
    check("done", 32'(ob.done), exp_done >= 0 ? 32'(1) << exp_done : 32'd0);
    if (v) begin
      check("bus", 32'(ob.bus), 32'(q[0]));
      check("byte_idx", 32'(ob.byte_idx), 32'(q.size() == 1));
      check("gnt", 32'(ob.gnt), 32'(1) << owner);
      check("bus_id", 32'(ob.bus_id), 32'(owner));
    end else begin
      check("bus_idle", 32'(ob.bus), 32'd0);
      check("byte_idx_idle", 32'(ob.byte_idx), 32'd0);
      check("gnt_idle", 32'(ob.gnt), 32'd0);
    end
  endtask
  task automatic model_reset();
    owner = -1;
    ptr = 0;
    exp_done = -1;
    q.delete();
  endtask
  task automatic model_step();
    logic [15:0] w;
    exp_done = -1;
    if (owner < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (ob.req[(ptr + k) % N]) owner = (ptr + k) % N;
      if (owner >= 0) begin
        w = ob.data[16*owner +: 16];
        q.push_back(w[15:8]);
        q.push_back(w[7:0]);
      end
    end else if (ob.bus_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        exp_done = owner;
        ptr = (owner + 1) % N;
        owner = -1;
      end
    end
  endtask
  task automatic drive(logic [N-1:0] r, logic [16*N-1:0] d, logic rdy);
    ob.req = r;
    ob.data = d;
    ob.bus_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask
  task automatic cycle(logic [N-1:0] r, logic [16*N-1:0] d, logic rdy);
    @(negedge clk);
    drive(r, d, rdy);
  endtask
  task automatic do_reset(logic [N-1:0] r);
    @(negedge clk);
    rst = 0;
    ob.req = r;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1;
    drive(r, ob.data, 1'b1);
  endtask
  function automatic logic [16*N-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction
  initial begin
    ob.req = '0;
    ob.data = '0;
    ob.bus_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("reset_bus_id", 32'(ob.bus_id), 32'd0);
    @(negedge clk);
    rst = 1;
    drive('0, '0, 1'b1);
    cycle(4'b0010, 64'h0000_0000_A55A_0000, 1'b1);
    check("single_hi", 32'(ob.bus), 32'h A5);
    cycle(4'b0010, 64'h0000_0000_A55A_0000, 1'b1);
    check("single_lo", 32'(ob.bus), 32'h5A);
    cycle(4'b0000, 64'h0000_0000_A55A_0000, 1'b1);
    check("single_done", 32'(ob.done), 32'b0010);
    cycle(4'b0000, '0, 1'b1);
    do_reset(4'b1111);
    repeat (16) cycle(4'b1111, rnd_data(), 1'b1);
    do_reset('0);
    cycle(4'b0100, rnd_data(), 1'b1);
    repeat (5) cycle(4'b0100, rnd_data(), 1'b0);
    repeat (3) cycle(4'b0100, rnd_data(), 1'b1);
    cycle(4'b1000, rnd_data(), 1'b1);
    cycle(4'b0000, rnd_data(), 1'b0);
    cycle(4'b0000, rnd_data(), 1'b1);
    cycle(4'b0000, rnd_data(), 1'b1);
    cycle(4'b0000, rnd_data(), 1'b1);
    cycle(4'b0010, rnd_data(), 1'b1);
    cycle(4'b0010, rnd_data(), 1'b1);
    check("mid_state_lo", 32'(ob.byte_idx), 32'd1);
    do_reset(4'b1010);
    repeat (8) cycle(4'b1010, rnd_data(), 1'b1);
    cycle(4'b1000, rnd_data(), 1'b1);
    repeat (3) cycle(4'b1001, rnd_data(), 1'b1);
    repeat (9) cycle(4'b1001, rnd_data(), 1'b1);
    for (int n = 0; n < 3000; n++)
      cycle(N'($urandom), rnd_data(), $urandom_range(0, 3) != 0);
    for (int n = 0; n < 10; n++) do_reset(N'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_bus_arbiter.md
# output_bus_arbiter

Round-robin arbiter and byte sequencer that shares one 8-bit output bus among N 16-bit result producers. It grants one requester at a time and captures its word. It then drives the word onto the bus as two bytes, high byte first, under a valid/ready handshake. It pulses a per-requester completion strobe when the low byte is accepted. It sits between the datapath result registers and the shared byte-wide output port.

## Interface
- N, default 4: number of requesters (2..8).
- IDW, default $clog2(N): width of requester index.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- req  in  N  per-requester transfer request, level; held until the matching done.
- data  in  16*N  requester words, flattened; requester i occupies [16*i+15:16*i].
- bus_ready  in  1  consumer accepts the current byte on a clk edge where bus_valid=1.
- bus  out  8  byte being offered.
- bus_valid  out  1  bus holds a valid byte.
- bus_id  out  IDW  index of the requester owning the current transfer.
- byte_idx  out  1  0 = high byte on bus, 1 = low byte on bus.
- gnt  out  N  one-hot grant, held for the whole transfer.
- done  out  N  one-cycle pulse on the granted bit after the low byte is accepted.
- busy  out  1  transfer in progress (state ≠ IDLE).

## Operation
- State machine states:
  - IDLE: nothing granted; bus_valid=0, bus=0.
  - SEND_HI: bus = word[15:8], byte_idx=0.
  - SEND_LO: bus = word[7:0], byte_idx=1.
- IDLE → SEND_HI: taken when |req=1.
  - The winner is the first set req bit, searching upward from rr_ptr modulo N.
  - Same edge: gnt[winner]=1, bus_id=winner, the 16-bit word is captured into hold_reg, bus_valid=1.
- SEND_HI → SEND_LO: on an edge with bus_ready=1.
- SEND_LO → IDLE: on an edge with bus_ready=1.
  - Same edge: gnt=0, bus_valid=0, done[bus_id]=1 for exactly one cycle.
  - rr_ptr = (bus_id+1) mod N; wraps from N-1 to 0.
- While bus_ready=0, bus, bus_valid, byte_idx, bus_id and gnt hold steady indefinitely.
- The word is captured at grant. Changes on data or req after grant do not affect the transfer.
- A requester dropping req mid-transfer does not abort the transfer. It completes and done still pulses.
- Requests arriving during a transfer wait. They are arbitrated in the IDLE cycle following the transfer.
- A requester re-asserting immediately after its own done loses to any other pending requester, because of the rr_ptr advance.
- No requests: the block stays in IDLE, and rr_ptr is unchanged.
- Reset values: state=IDLE, rr_ptr=0, hold_reg=0, bus=0, bus_valid=0, bus_id=0, byte_idx=0, gnt=0, done=0, busy=0.
- Reset asserted mid-transfer: the transfer is discarded and no done is issued. Requesters must keep req asserted to be re-served after reset.

## Timing
- Grant latency: 1 cycle. A req sampled high in IDLE at edge t gives gnt and bus_valid high after edge t.
- Minimum transfer: 3 cycles with bus_ready tied high (IDLE, SEND_HI, SEND_LO).
- done coincides with the return to IDLE. The earliest next grant is the following edge.
- All outputs are registered; there is no combinational path from bus_ready or req to any output.

## Structure
- Shared package output_bus_pkg holds:
  - state enum {IDLE, SEND_HI, SEND_LO};
  - localparams WORD_W=16 and BYTE_W=8.
- Sub-module rr_arbiter (N): combinational round-robin pick.
  - Inputs: req and rr_ptr.
  - Outputs: winner index and any_req.
  - It is instantiated once; the FSM owns the registers.

## Test plan
- Single request: req=4'b0010, data[31:16]=16'hA55A, bus_ready=1.
  - Expect: gnt=0010 and bus=8'hA5 (byte_idx=0), then bus=8'h5A (byte_idx=1).
  - Then done=0010 for one cycle and busy=0.
- Simultaneous requests: req=4'b1111 held, bus_ready=1, from reset.
  - Expect grant order 0,1,2,3,0.
  - Each transfer takes 3 cycles, and done pulses match the order.
- Back-pressure: bus_ready=0 for 5 cycles in SEND_HI, then 1.
  - Expect bus, bus_id and bus_valid stable throughout; advance to SEND_LO only on the ready edge.
- Data change and drop: change data[i] and deassert req[i] one cycle after grant.
  - Expect the original captured bytes on bus and done[i] still pulsing.
- Reset mid-transfer: assert rst=0 in SEND_LO.
  - Expect all outputs 0 immediately with no done pulse.
  - After release with req still high, the transfer restarts from requester 0's search position.
- Wrap and fairness: req=4'b1001, with requester 3 served last.
  - Expect the next grant to go to 0; requester 3 re-asserting loses to requester 0.
